ring_input_buffer: RTL and testbench
====================================

// Module: ring_input_buffer
// PURPOSE
//  Per-output-port ingress stage of the ring router; sits directly upstream of the switch allocator.
//  Holds two slot arrays: HIGH (in-transit ring traffic) and LOW (local injection), each with per-slot route info.
//  Allocates free slots on arrival and timestamps injected packets.
//  Frees exactly the slot the allocator grants, the cycle after the grant.
// PARAMETERS
//  PACKET_SIZE  49     packet width; [48]=valid, [47:32]=timestamp (smaller=older), [31:16]=dest id, [15:0]=payload
//  BUFFER_SIZE  4      slots per priority array (allocator compares 4 slots)
//  OUT_PORT     2'b01  route code for "forward along ring"
//  EJECT_PORT   2'b10  route code for "deliver to local node"
//  LOCAL_ID     16'd0  this router's node id
// PORTS
//  clk                 in   1                 clock
//  rst_n               in   1                 asynchronous active-low reset
//  ring_in_packet      in   PACKET_SIZE       packet from upstream ring link; valid when [48]=1
//  ring_in_ready       out  1                 HIGH array has a free slot; upstream sends only when 1
//  inject_packet       in   PACKET_SIZE       local injection; [47:32] ignored and overwritten
//  inject_valid        in   1                 injection request
//  inject_ready        out  1                 LOW array has a free slot
//  grant_pos           in   16                slot index granted by the allocator
//  grant_pos_valid     in   1                 grant strobe
//  grant_in_high       in   1                 1=grant refers to HIGH array, 0=LOW array
//  buffer_high_prior   out  PACKET_SIZE x BUFFER_SIZE  HIGH slots (unpacked array)
//  buffer_low_prior    out  PACKET_SIZE x BUFFER_SIZE  LOW slots (unpacked array)
//  buffer_high_prior_route_info out 16 x BUFFER_SIZE   route code per HIGH slot
//  buffer_low_prior_route_info  out 16 x BUFFER_SIZE   route code per LOW slot
//  high_count / low_count       out $clog2(BUFFER_SIZE+1)  occupied slots per array
//  grant_error         out  1                 sticky: grant to an empty or out-of-range slot
// BEHAVIOUR
//  Reset (asynchronous, any time, including mid-operation):
//   - All slots = 0 and all route_info = 0.
//   - Counts = 0; ready outputs = 1; grant_error = 0; timestamp counter = 0.
//  Timestamp counter: 16-bit, free-running, +1 per cycle, wraps 16'hFFFF->0.
//   - Wrap causes no special handling; ordering across a wrap is not guaranteed.
//  Ready outputs are combinational from registered occupancy only.
//   - ready = (count < BUFFER_SIZE).
//   - A slot freed in the same cycle does not raise ready.
//  Write (1-cycle latency):
//   - HIGH: when ring_in_packet[48] && ring_in_ready, the packet goes to the lowest-index empty slot
//     (empty = slot[48]==0, from registered state) at the next edge, unmodified.
//   - LOW: when inject_valid && inject_ready, the LOW lowest empty slot gets the packet
//     with [48]=1 and [47:32]=timestamp counter value in that cycle.
//   - ring_in_packet[48]=1 while ring_in_ready=0 is dropped.
//  Route compute, registered together with the slot:
//   - route = (dest==LOCAL_ID) ? EJECT_PORT : OUT_PORT, zero-extended to 16 bits.
//   - Empty slot route = 0.
//  Grant/free:
//   - grant_pos_valid with grant_pos < BUFFER_SIZE and a valid target slot
//     clears that slot and its route to 0 at the next edge.
//   - A grant to an empty slot or grant_pos >= BUFFER_SIZE changes no state and sets grant_error.
//  Simultaneous write + grant on the same array in one cycle:
//   - Both take effect; the write picks from pre-grant empty slots, so it never targets the slot being freed.
//   - Count is unchanged (+1 -1).
//  Counts: next = count + write - legal_grant; never exceed BUFFER_SIZE, never below 0.
//  Slots are not FIFO-ordered; age ordering is carried solely by [47:32].
// TESTING
//  1. Reset, inject 4 LOW (dest=5) on cycles 0-3 -> LOW slots 0..3 valid, timestamps 0,1,2,3;
//     route=OUT_PORT; low_count=4; inject_ready=0.
//  2. Ring packet dest=LOCAL_ID -> HIGH slot0 valid next cycle, route=EJECT_PORT, timestamp preserved.
//  3. Full LOW; grant pos=2 (low) and inject in the same cycle -> slot2 cleared, no write;
//     next cycle inject_ready=1, new inject lands in slot2.
//  4. HIGH count=2 (slots 0,1); write + grant pos=0 in the same cycle ->
//     new packet in slot2, slot0 empty, high_count=2.
//  5. Grant to empty slot 3 and grant_pos=7 -> no state change, grant_error=1 until reset.
//  6. Drive counter to 16'hFFFE, inject 3 packets -> stamps FFFE, FFFF, 0000;
//     assert rst_n low mid-stream -> all outputs zero immediately.

Source files
------------

// File: rtl/ring_input_buffer_if.sv
// Bundles the ring-ingress, injection and allocator-grant signals of one ring_input_buffer.
// The bench or upstream logic drives the master side; the buffer sits on the slave side.
interface ring_input_buffer_if #(
  parameter int PACKET_SIZE = 49,
  parameter int BUFFER_SIZE = 4
);
  localparam int COUNT_W = $clog2(BUFFER_SIZE + 1);

  logic [PACKET_SIZE-1:0] ring_in_packet;
  logic                   ring_in_ready;
  logic [PACKET_SIZE-1:0] inject_packet;
  logic                   inject_valid;
  logic                   inject_ready;
  logic [15:0]            grant_pos;
  logic                   grant_pos_valid;
  logic                   grant_in_high;
  logic [PACKET_SIZE-1:0] buffer_high_prior [BUFFER_SIZE];
  logic [PACKET_SIZE-1:0] buffer_low_prior [BUFFER_SIZE];
  logic [15:0]            buffer_high_prior_route_info [BUFFER_SIZE];
  logic [15:0]            buffer_low_prior_route_info [BUFFER_SIZE];
  logic [COUNT_W-1:0]     high_count;
  logic [COUNT_W-1:0]     low_count;
  logic                   grant_error;

  modport master (
    output ring_in_packet, inject_packet, inject_valid,
           grant_pos, grant_pos_valid, grant_in_high,
    input  ring_in_ready, inject_ready,
           buffer_high_prior, buffer_low_prior,
           buffer_high_prior_route_info, buffer_low_prior_route_info,
           high_count, low_count, grant_error
  );

  modport slave (
    input  ring_in_packet, inject_packet, inject_valid,
           grant_pos, grant_pos_valid, grant_in_high,
    output ring_in_ready, inject_ready,
           buffer_high_prior, buffer_low_prior,
           buffer_high_prior_route_info, buffer_low_prior_route_info,
           high_count, low_count, grant_error
  );
endinterface

// File: rtl/ring_input_buffer.sv
// Ring router ingress stage: HIGH (ring transit) and LOW (local injection) slot arrays with
// per-slot route codes, timestamped injection and allocator-driven slot release.
module ring_input_buffer #(
  parameter int          PACKET_SIZE = 49,
  parameter int          BUFFER_SIZE = 4,
  parameter logic [1:0]  OUT_PORT    = 2'b01,
  parameter logic [1:0]  EJECT_PORT  = 2'b10,
  parameter logic [15:0] LOCAL_ID    = 16'd0
) (
  input logic               clk,
  input logic               rst_n,
  ring_input_buffer_if.slave bus
);

  localparam int COUNT_W   = $clog2(BUFFER_SIZE + 1);
  localparam int IDX_W     = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int VALID_BIT = PACKET_SIZE - 1;

  logic [PACKET_SIZE-1:0] high_slot [BUFFER_SIZE];
  logic [PACKET_SIZE-1:0] low_slot [BUFFER_SIZE];
  logic [15:0]            high_route [BUFFER_SIZE];
  logic [15:0]            low_route [BUFFER_SIZE];
  logic [COUNT_W-1:0]     high_cnt;
  logic [COUNT_W-1:0]     low_cnt;
  logic                   err;
  logic [15:0]            timestamp;

  logic [BUFFER_SIZE-1:0] high_occ;
  logic [BUFFER_SIZE-1:0] low_occ;
  logic [IDX_W-1:0]       high_free_idx;
  logic [IDX_W-1:0]       low_free_idx;
  logic [IDX_W-1:0]       grant_idx;
  logic                   high_ready;
  logic                   low_ready;
  logic                   high_write;
  logic                   low_write;
  logic                   grant_in_range;
  logic                   grant_target_valid;
  logic                   grant_legal;
  logic                   high_release;
  logic                   low_release;
  logic [PACKET_SIZE-1:0] low_stamped;

  function automatic logic [IDX_W-1:0] lowest_free(input logic [BUFFER_SIZE-1:0] occ);
    lowest_free = '0;
    for (int i = BUFFER_SIZE - 1; i >= 0; i--)
      if (!occ[i]) lowest_free = IDX_W'(i);
  endfunction

  function automatic logic [15:0] route_of(input logic [PACKET_SIZE-1:0] pkt);
    route_of = (pkt[31:16] == LOCAL_ID) ? {14'd0, EJECT_PORT} : {14'd0, OUT_PORT};
  endfunction

  always_comb begin
    high_occ = '0;
    low_occ  = '0;
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      high_occ[i] = high_slot[i][VALID_BIT];
      low_occ[i]  = low_slot[i][VALID_BIT];
    end
  end

  // Ready looks only at registered occupancy, so a release this cycle cannot admit a write.
  assign high_ready = (high_cnt < COUNT_W'(BUFFER_SIZE));
  assign low_ready  = (low_cnt < COUNT_W'(BUFFER_SIZE));

  assign high_free_idx = lowest_free(high_occ);
  assign low_free_idx  = lowest_free(low_occ);
  assign high_write    = bus.ring_in_packet[VALID_BIT] && high_ready;
  assign low_write     = bus.inject_valid && low_ready;
  assign low_stamped   = {1'b1, timestamp, bus.inject_packet[31:0]};

  assign grant_in_range     = (bus.grant_pos < 16'(BUFFER_SIZE));
  assign grant_idx          = bus.grant_pos[IDX_W-1:0];
  assign grant_target_valid = bus.grant_in_high ? high_occ[grant_idx] : low_occ[grant_idx];
  assign grant_legal        = bus.grant_pos_valid && grant_in_range && grant_target_valid;
  assign high_release       = grant_legal && bus.grant_in_high;
  assign low_release        = grant_legal && !bus.grant_in_high;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timestamp <= '0;
    else        timestamp <= timestamp + 16'd1;
  end

  // Write slots come from pre-release occupancy, so a write never lands on the slot being freed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        high_slot[i]  <= '0;
        low_slot[i]   <= '0;
        high_route[i] <= '0;
        low_route[i]  <= '0;
      end
      high_cnt <= '0;
      low_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      if (high_release) begin
        high_slot[grant_idx]  <= '0;
        high_route[grant_idx] <= '0;
      end
      if (low_release) begin
        low_slot[grant_idx]  <= '0;
        low_route[grant_idx] <= '0;
      end
      if (high_write) begin
        high_slot[high_free_idx]  <= bus.ring_in_packet;
        high_route[high_free_idx] <= route_of(bus.ring_in_packet);
      end
      if (low_write) begin
        low_slot[low_free_idx]  <= low_stamped;
        low_route[low_free_idx] <= route_of(bus.inject_packet);
      end
      high_cnt <= high_cnt + COUNT_W'(high_write) - COUNT_W'(high_release);
      low_cnt  <= low_cnt + COUNT_W'(low_write) - COUNT_W'(low_release);
      if (bus.grant_pos_valid && !grant_legal) err <= 1'b1;
    end
  end

  assign bus.ring_in_ready                = high_ready;
  assign bus.inject_ready                 = low_ready;
  assign bus.buffer_high_prior            = high_slot;
  assign bus.buffer_low_prior             = low_slot;
  assign bus.buffer_high_prior_route_info = high_route;
  assign bus.buffer_low_prior_route_info  = low_route;
  assign bus.high_count                   = high_cnt;
  assign bus.low_count                    = low_cnt;
  assign bus.grant_error                  = err;

endmodule

// File: tb/tb_ring_input_buffer.sv
// Self-checking bench for ring_input_buffer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a slot-level behavioural model.
module tb_ring_input_buffer;

  localparam int PS = 49;
  localparam int BS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ring_input_buffer_if #(.PACKET_SIZE(PS), .BUFFER_SIZE(BS)) bus ();

  ring_input_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [PS-1:0] m_high [BS];
  logic [PS-1:0] m_low [BS];
  logic [15:0]   m_high_rt [BS];
  logic [15:0]   m_low_rt [BS];
  logic          m_err;
  logic [15:0]   m_ts;

  function automatic logic [PS-1:0] mk(input logic v, input logic [15:0] ts,
                                       input logic [15:0] dest, input logic [15:0] pay);
    mk = {v, ts, dest, pay};
  endfunction

  function automatic int m_count(input bit high);
    m_count = 0;
    for (int i = 0; i < BS; i++)
      if (high ? m_high[i][PS-1] : m_low[i][PS-1]) m_count++;
  endfunction

  function automatic logic [15:0] m_route(input logic [15:0] dest);
    m_route = (dest == 16'd0) ? 16'd2 : 16'd1;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: each edge, admit writes by occupancy, pick lowest empty slot before any release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BS; i++) begin
        m_high[i] = '0; m_low[i] = '0; m_high_rt[i] = '0; m_low_rt[i] = '0;
      end
      m_err = 1'b0;
      m_ts  = 16'd0;
    end else begin
      int hi_idx;
      int lo_idx;
      hi_idx = -1;
      lo_idx = -1;
      if (bus.ring_in_packet[PS-1] && m_count(1) < BS)
        for (int i = BS - 1; i >= 0; i--) if (!m_high[i][PS-1]) hi_idx = i;
      if (bus.inject_valid && m_count(0) < BS)
        for (int i = BS - 1; i >= 0; i--) if (!m_low[i][PS-1]) lo_idx = i;
      if (bus.grant_pos_valid) begin
        if (bus.grant_pos < BS && bus.grant_in_high && m_high[bus.grant_pos[1:0]][PS-1]) begin
          m_high[bus.grant_pos[1:0]] = '0;
          m_high_rt[bus.grant_pos[1:0]] = '0;
        end else if (bus.grant_pos < BS && !bus.grant_in_high && m_low[bus.grant_pos[1:0]][PS-1]) begin
          m_low[bus.grant_pos[1:0]] = '0;
          m_low_rt[bus.grant_pos[1:0]] = '0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (hi_idx >= 0) begin
        m_high[hi_idx]    = bus.ring_in_packet;
        m_high_rt[hi_idx] = m_route(bus.ring_in_packet[31:16]);
      end
      if (lo_idx >= 0) begin
        m_low[lo_idx]    = mk(1'b1, m_ts, bus.inject_packet[31:16], bus.inject_packet[15:0]);
        m_low_rt[lo_idx] = m_route(bus.inject_packet[31:16]);
      end
      m_ts = m_ts + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("high_count", 64'(bus.high_count), 64'(m_count(1)));
      check_output("low_count", 64'(bus.low_count), 64'(m_count(0)));
      check_output("ring_in_ready", 64'(bus.ring_in_ready), 64'(m_count(1) < BS));
      check_output("inject_ready", 64'(bus.inject_ready), 64'(m_count(0) < BS));
      check_output("grant_error", 64'(bus.grant_error), 64'(m_err));
      for (int i = 0; i < BS; i++) begin
        check_output($sformatf("high_slot%0d", i), 64'(bus.buffer_high_prior[i]), 64'(m_high[i]));
        check_output($sformatf("low_slot%0d", i), 64'(bus.buffer_low_prior[i]), 64'(m_low[i]));
        check_output($sformatf("high_route%0d", i), 64'(bus.buffer_high_prior_route_info[i]), 64'(m_high_rt[i]));
        check_output($sformatf("low_route%0d", i), 64'(bus.buffer_low_prior_route_info[i]), 64'(m_low_rt[i]));
      end
    end
  end

  task automatic set_idle();
    bus.ring_in_packet  = '0;
    bus.inject_packet   = '0;
    bus.inject_valid    = 1'b0;
    bus.grant_pos       = '0;
    bus.grant_pos_valid = 1'b0;
    bus.grant_in_high   = 1'b0;
  endtask

  // Drives one cycle of inputs, consumes the next edge, returns 1 time unit after it.
  task automatic apply_stimulus(input logic [PS-1:0] ring, input logic inj_v, input logic [PS-1:0] inj,
                                input logic gv, input logic [15:0] gpos, input logic gh);
    bus.ring_in_packet  = ring;
    bus.inject_valid    = inj_v;
    bus.inject_packet   = inj;
    bus.grant_pos_valid = gv;
    bus.grant_pos       = gpos;
    bus.grant_in_high   = gh;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_high_count"}, 64'(bus.high_count), 64'd0);
    check_output({tag, "_low_count"}, 64'(bus.low_count), 64'd0);
    check_output({tag, "_ring_ready"}, 64'(bus.ring_in_ready), 64'd1);
    check_output({tag, "_inject_ready"}, 64'(bus.inject_ready), 64'd1);
    check_output({tag, "_grant_error"}, 64'(bus.grant_error), 64'd0);
    for (int i = 0; i < BS; i++) begin
      check_output($sformatf("%s_low_slot%0d", tag, i), 64'(bus.buffer_low_prior[i]), 64'd0);
      check_output($sformatf("%s_high_slot%0d", tag, i), 64'(bus.buffer_high_prior[i]), 64'd0);
    end
  endtask

  localparam logic [PS-1:0] NONE = '0;

  initial begin
    set_idle();
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    do_reset();
    check_all_zero("reset");

    // Four injections on consecutive cycles take timestamps 0..3.
    for (int i = 0; i < 4; i++)
      apply_stimulus(NONE, 1'b1, mk(1'b0, 16'h0, 16'd5, 16'(16'h10 + i)), 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("t1_low_slot%0d", i), 64'(bus.buffer_low_prior[i]),
                   64'(mk(1'b1, 16'(i), 16'd5, 16'(16'h10 + i))));
      check_output($sformatf("t1_low_route%0d", i), 64'(bus.buffer_low_prior_route_info[i]), 64'd1);
    end
    check_output("t1_low_count", 64'(bus.low_count), 64'd4);
    check_output("t1_inject_ready", 64'(bus.inject_ready), 64'd0);

    apply_stimulus(mk(1'b1, 16'h1234, 16'd0, 16'hABCD), 1'b0, NONE, 1'b0, 16'd0, 1'b0);
    check_output("t2_high_slot0", 64'(bus.buffer_high_prior[0]), 64'(mk(1'b1, 16'h1234, 16'd0, 16'hABCD)));
    check_output("t2_high_route0", 64'(bus.buffer_high_prior_route_info[0]), 64'd2);
    check_output("t2_high_count", 64'(bus.high_count), 64'd1);

    apply_stimulus(NONE, 1'b1, mk(1'b0, 16'h0, 16'd5, 16'h77), 1'b1, 16'd2, 1'b0);
    check_output("t3_low_slot2_cleared", 64'(bus.buffer_low_prior[2]), 64'd0);
    check_output("t3_low_count", 64'(bus.low_count), 64'd3);
    check_output("t3_inject_ready", 64'(bus.inject_ready), 64'd1);
    apply_stimulus(NONE, 1'b1, mk(1'b0, 16'h0, 16'd5, 16'h77), 1'b0, 16'd0, 1'b0);
    check_output("t3_low_slot2_refill", 64'(bus.buffer_low_prior[2]), 64'(mk(1'b1, 16'd6, 16'd5, 16'h77)));
    check_output("t3_low_count_full", 64'(bus.low_count), 64'd4);

    apply_stimulus(mk(1'b1, 16'h0042, 16'd9, 16'h1), 1'b0, NONE, 1'b0, 16'd0, 1'b0);
    apply_stimulus(mk(1'b1, 16'h0043, 16'd3, 16'h2), 1'b0, NONE, 1'b1, 16'd0, 1'b1);
    check_output("t4_high_slot2", 64'(bus.buffer_high_prior[2]), 64'(mk(1'b1, 16'h0043, 16'd3, 16'h2)));
    check_output("t4_high_route2", 64'(bus.buffer_high_prior_route_info[2]), 64'd1);
    check_output("t4_high_slot0", 64'(bus.buffer_high_prior[0]), 64'd0);
    check_output("t4_high_count", 64'(bus.high_count), 64'd2);

    apply_stimulus(NONE, 1'b0, NONE, 1'b1, 16'd3, 1'b1);
    check_output("t5_error_empty", 64'(bus.grant_error), 64'd1);
    check_output("t5_high_count", 64'(bus.high_count), 64'd2);
    apply_stimulus(NONE, 1'b0, NONE, 1'b1, 16'd7, 1'b0);
    check_output("t5_low_count", 64'(bus.low_count), 64'd4);
    repeat (3) @(posedge clk);
    #1;
    check_output("t5_error_sticky", 64'(bus.grant_error), 64'd1);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [PS-1:0] ring;
      logic [PS-1:0] inj;
      logic [15:0]   d1;
      logic [15:0]   d2;
      d1 = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      d2 = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      ring = mk(1'($urandom_range(0, 9) < 6), 16'($urandom), d1, 16'($urandom));
      inj  = mk(1'($urandom), 16'($urandom), d2, 16'($urandom));
      apply_stimulus(ring, 1'($urandom_range(0, 9) < 6), inj,
                     1'($urandom_range(0, 9) < 6), 16'($urandom_range(0, 5)), 1'($urandom));
    end

    do_reset();
    check_output("t6_error_cleared", 64'(bus.grant_error), 64'd0);
    repeat (65534) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      apply_stimulus(NONE, 1'b1, mk(1'b0, 16'h0, 16'd8, 16'(i)), 1'b0, 16'd0, 1'b0);
    check_output("t6_stamp_fffe", 64'(bus.buffer_low_prior[0]), 64'(mk(1'b1, 16'hFFFE, 16'd8, 16'd0)));
    check_output("t6_stamp_ffff", 64'(bus.buffer_low_prior[1]), 64'(mk(1'b1, 16'hFFFF, 16'd8, 16'd1)));
    check_output("t6_stamp_0000", 64'(bus.buffer_low_prior[2]), 64'(mk(1'b1, 16'h0000, 16'd8, 16'd2)));
    bus.inject_valid  = 1'b1;
    bus.inject_packet = mk(1'b0, 16'h0, 16'd8, 16'd3);
    bus.ring_in_packet = mk(1'b1, 16'h5, 16'd0, 16'd4);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_midreset");
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
